sec_ksa_n3k32: RTL and testbench

- Masked 32-bit adder for Boolean-to-arithmetic conversion: z = x + y mod 2^32 on 3-share Boolean-masked operands, result also 3-share Boolean-masked.
- Kogge-Stone prefix network; every AND is a 3-share masked AND (DOM style) consuming fresh randomness.
- Fully pipelined, one operation per cycle, 6-cycle latency.

---
 rtl/sec_ksa_n3k32_pkg.sv | 29 ++
 rtl/sec_and_n3.sv | 61 ++++++
 rtl/sec_ksa_n3k32.sv | 98 +++++++++
 tb/tb_sec_ksa_n3k32.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sec_ksa_n3k32_pkg.sv
// Shared constants and share-packing helpers for the 3-share masked 32-bit adder.
package sec_ksa_n3k32_pkg;

    localparam int unsigned N      = 3;       // share count
    localparam int unsigned K      = 32;      // word width
    localparam int unsigned W      = N * K;   // packed shares width
    localparam int unsigned RW     = 3 * K;   // random bits per masked AND (r01, r02, r12)
    localparam int unsigned Levels = 5;       // prefix levels for 32 bits

    // Randomness slice indices into i_n
    localparam int unsigned RndG0    = 0;     // G0 = SecAND(x, y)
    localparam int unsigned RndGBase = 0;     // G-AND of level j uses slice RndGBase + j
    localparam int unsigned RndPBase = 5;     // P-AND of level j uses slice RndPBase + j

    // Extract share s from a packed share vector
    function automatic logic [K-1:0] get_share(input logic [W-1:0] v, input int unsigned s);
        return v[s*K +: K];
    endfunction

    // Shift every share left by sh with zero fill; linear, so safe to apply sharewise
    function automatic logic [W-1:0] shl_shares(input logic [W-1:0] v, input int unsigned sh);
        logic [W-1:0] res;
        for (int unsigned i = 0; i < N; i++) begin
            res[i*K +: K] = get_share(v, i) << sh;
        end
        return res;
    endfunction

endpackage

// File: rtl/sec_and_n3.sv
// 3-share DOM-style masked AND over a 32-bit lane vector. Cross terms are refreshed
// with fresh randomness and all nine terms are registered before compression, so
// no glitch can combine shares of the same operand across the register boundary.
module sec_and_n3
    import sec_ksa_n3k32_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [RW-1:0] r,
    output logic [W-1:0]  c
);

    logic [K-1:0] r01, r02, r12;
    logic [K-1:0] a0, a1, a2, b0, b1, b2;
    logic [K-1:0] t_d [9];
    logic [K-1:0] t_q [9];

    assign r01 = r[0   +: K];
    assign r02 = r[K   +: K];
    assign r12 = r[2*K +: K];

    assign a0 = get_share(a, 0);
    assign a1 = get_share(a, 1);
    assign a2 = get_share(a, 2);
    assign b0 = get_share(b, 0);
    assign b1 = get_share(b, 1);
    assign b2 = get_share(b, 2);

    // Form the nine partial products; index 3*i+k belongs to output share i
    always_comb begin
        t_d[0] = a0 & b0;
        t_d[1] = (a0 & b1) ^ r01;
        t_d[2] = (a0 & b2) ^ r02;
        t_d[3] = a1 & b1;
        t_d[4] = (a1 & b0) ^ r01;
        t_d[5] = (a1 & b2) ^ r12;
        t_d[6] = a2 & b2;
        t_d[7] = (a2 & b0) ^ r02;
        t_d[8] = (a2 & b1) ^ r12;
    end

    // Term registers; hold while a bubble passes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) t_q[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < 9; i++) t_q[i] <= t_d[i];
        end
    end

    // Compress registered terms per share
    always_comb begin
        c[0*K +: K] = t_q[0] ^ t_q[1] ^ t_q[2];
        c[1*K +: K] = t_q[3] ^ t_q[4] ^ t_q[5];
        c[2*K +: K] = t_q[6] ^ t_q[7] ^ t_q[8];
    end

endmodule

// File: rtl/sec_ksa_n3k32.sv
// Masked Kogge-Stone adder, z = x + y mod 2^32 on 3-share Boolean-masked operands.
// Six register stages: G0 terms, then one stage per prefix level.
module sec_ksa_n3k32
    import sec_ksa_n3k32_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_dvld,
    input  logic               i_rvld,
    input  logic [10*RW-1:0]   i_n,
    input  logic [W-1:0]       i_x,
    input  logic [W-1:0]       i_y,
    output logic [W-1:0]       o_z,
    output logic               o_dvld
);

    logic         acc;
    logic         vld_q   [Levels+1];
    logic [W-1:0] p0_q    [Levels+1];   // P0 copy aligned to each stage
    logic [W-1:0] gprev_q [1:Levels];   // G_{j-1} copy registered in stage j
    logic [W-1:0] gand_c  [Levels+1];   // compressed G-AND outputs, index = level
    logic [W-1:0] pand_c  [1:Levels-1]; // compressed P-AND outputs, index = level
    logic [W-1:0] g_cur   [Levels+1];   // G_j as seen after stage j
    logic [W-1:0] p_prev  [1:Levels];   // P_{j-1} feeding level j

    assign acc = i_dvld & i_rvld;

    sec_and_n3 u_and_g0 (
        .clk (clk_i),
        .rst (rst_i),
        .en  (acc),
        .a   (i_x),
        .b   (i_y),
        .r   (i_n[RndG0*RW +: RW]),
        .c   (gand_c[0])
    );

    assign g_cur[0]  = gand_c[0];
    assign p_prev[1] = p0_q[0];

    for (genvar j = 1; j <= Levels; j++) begin : g_level
        localparam int unsigned Sh = 1 << (j - 1);

        assign g_cur[j] = gprev_q[j] ^ gand_c[j];

        sec_and_n3 u_and_g (
            .clk (clk_i),
            .rst (rst_i),
            .en  (vld_q[j-1]),
            .a   (p_prev[j]),
            .b   (shl_shares(g_cur[j-1], Sh)),
            .r   (i_n[(RndGBase+j)*RW +: RW]),
            .c   (gand_c[j])
        );

        // P5 is never needed, so the last level has no P-AND
        if (j < Levels) begin : g_pand
            sec_and_n3 u_and_p (
                .clk (clk_i),
                .rst (rst_i),
                .en  (vld_q[j-1]),
                .a   (p_prev[j]),
                .b   (shl_shares(p_prev[j], Sh)),
                .r   (i_n[(RndPBase+j)*RW +: RW]),
                .c   (pand_c[j])
            );
            assign p_prev[j+1] = pand_c[j];
        end
    end

    // Valid chain plus aligned P0/G copies; data holds whenever a bubble passes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j <= Levels; j++) begin
                vld_q[j] <= 1'b0;
                p0_q[j]  <= '0;
            end
            for (int j = 1; j <= Levels; j++) gprev_q[j] <= '0;
        end else begin
            vld_q[0] <= acc;
            if (acc) p0_q[0] <= i_x ^ i_y;
            for (int j = 1; j <= Levels; j++) begin
                vld_q[j] <= vld_q[j-1];
                if (vld_q[j-1]) begin
                    gprev_q[j] <= g_cur[j-1];
                    p0_q[j]    <= p0_q[j-1];
                end
            end
        end
    end

    // Sum = P0 ^ (carries << 1), sharewise
    always_comb begin
        o_z    = p0_q[Levels] ^ shl_shares(g_cur[Levels], 1);
        o_dvld = vld_q[Levels];
    end

endmodule

// File: tb/tb_sec_ksa_n3k32.sv
// Directed self-checking bench for the masked Kogge-Stone adder.
module tb_sec_ksa_n3k32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         i_dvld = 1'b0;
    logic         i_rvld = 1'b0;
    logic [959:0] i_n = '0;
    logic [95:0]  i_x = '0;
    logic [95:0]  i_y = '0;
    logic [95:0]  o_z;
    logic         o_dvld;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int NVec = 1000;
    logic [31:0] vx [NVec];
    logic [31:0] vy [NVec];

    sec_ksa_n3k32 dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_dvld (i_dvld),
        .i_rvld (i_rvld),
        .i_n    (i_n),
        .i_x    (i_x),
        .i_y    (i_y),
        .o_z    (o_z),
        .o_dvld (o_dvld)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] unmask(input logic [95:0] v);
        return v[31:0] ^ v[63:32] ^ v[95:64];
    endfunction

    function automatic logic [95:0] mask(input logic [31:0] v);
        logic [31:0] s0, s1;
        s0 = $urandom;
        s1 = $urandom;
        return {v ^ s0 ^ s1, s1, s0};
    endfunction

    // nmode: 0 random, 1 all zeros, 2 all ones
    task automatic set_inputs(input logic [31:0] x, input logic [31:0] y,
                              input logic dv, input logic rv, input int nmode);
        i_x    = mask(x);
        i_y    = mask(y);
        i_dvld = dv;
        i_rvld = rv;
        for (int w = 0; w < 30; w++) begin
            i_n[w*32 +: 32] = (nmode == 0) ? $urandom : (nmode == 1) ? 32'h0 : 32'hFFFF_FFFF;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        set_inputs(32'h1234, 32'h5678, 1'b1, 1'b1, 0);
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++;
        if (o_dvld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_dvld: got %b want 0", o_dvld);
        end
        n_cmp++;
        if (o_z !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_z: got %h want 0", o_z);
        end
        set_inputs(32'h0, 32'h0, 1'b0, 1'b0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        int edges;
        logic [95:0] zhold;
        @(negedge clk_i);
        set_inputs(32'h5, 32'h3, 1'b1, 1'b1, 0);
        edges = 0;
        do begin
            @(posedge clk_i);
            edges++;
            #1;
            set_inputs(32'h0, 32'h0, 1'b0, 1'b1, 0);
        end while (!o_dvld && edges < 20);
        n_cmp++;
        if (edges !== 6) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d edges want 6", edges);
        end
        n_cmp++;
        if (unmask(o_z) !== 32'h8) begin
            n_bad++;
            $display("FAIL basic_sum: got %h want 00000008", unmask(o_z));
        end
        zhold = o_z;
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (o_dvld !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_dvld_drop: got %b want 0", o_dvld);
        end
        n_cmp++;
        if (o_z !== zhold) begin
            n_bad++;
            $display("FAIL basic_hold: got %h want %h", o_z, zhold);
        end
    endtask

    task automatic test_carry();
        logic [31:0] tx [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] ty [4] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h9ABC_DEF0};
        logic [31:0] te [4] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'hACF1_3568};
        for (int k = 0; k < 4; k++) begin
            int edges;
            set_inputs(tx[k], ty[k], 1'b1, 1'b1, 0);
            edges = 0;
            do begin
                @(posedge clk_i);
                edges++;
                #1;
                set_inputs(32'h0, 32'h0, 1'b0, 1'b0, 0);
            end while (!o_dvld && edges < 20);
            n_cmp++;
            if (!o_dvld || unmask(o_z) !== te[k]) begin
                n_bad++;
                $display("FAIL carry_%0d: got %h (vld %b) want %h", k, unmask(o_z), o_dvld, te[k]);
            end
        end
    endtask

    // Streams vectors; rv_gap>0 pulls i_rvld low every rv_gap-th cycle
    task automatic run_stream(input string tag, input int cnt, input int rv_gap,
                              input int nmode);
        logic [31:0] exp_q [$];
        logic [95:0] last_z;
        logic        seen;
        logic        rv;
        int          idx, got, cyc;
        idx = 0; got = 0; cyc = 0; seen = 1'b0; last_z = '0;
        while ((idx < cnt || exp_q.size() != 0) && cyc < 4 * cnt + 50) begin
            rv = !(rv_gap > 0 && (cyc % rv_gap) == rv_gap - 1);
            if (idx < cnt) begin
                set_inputs(vx[idx], vy[idx], 1'b1, rv, nmode);
                if (rv) begin
                    exp_q.push_back(vx[idx] + vy[idx]);
                    idx++;
                end
            end else begin
                set_inputs(32'h0, 32'h0, 1'b0, 1'b1, nmode);
            end
            @(posedge clk_i);
            #1;
            cyc++;
            if (o_dvld) begin
                logic [31:0] e;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                got++;
                n_cmp++;
                if (unmask(o_z) !== e) begin
                    n_bad++;
                    $display("FAIL %s_sum[%0d]: got %h want %h", tag, got - 1, unmask(o_z), e);
                end
                seen = 1'b1;
            end else if (seen) begin
                n_cmp++;
                if (o_z !== last_z) begin
                    n_bad++;
                    $display("FAIL %s_hold: got %h want %h", tag, o_z, last_z);
                end
            end
            last_z = o_z;
        end
        set_inputs(32'h0, 32'h0, 1'b0, 1'b0, 0);
        n_cmp++;
        if (got !== cnt) begin
            n_bad++;
            $display("FAIL %s_count: got %0d results want %0d", tag, got, cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NVec; k++) begin
            vx[k] = $urandom;
            vy[k] = $urandom;
        end
        run_stream("b2b", NVec, 0, 0);
    endtask

    task automatic test_bubbles();
        run_stream("bubble", NVec, 3, 0);
    endtask

    task automatic test_fixed_rand();
        run_stream("nzero", 16, 0, 1);
        run_stream("nones", 16, 0, 2);
    endtask

    task automatic test_async_reset();
        int stale;
        for (int k = 0; k < 3; k++) begin
            set_inputs(32'h100 + k, 32'h55, 1'b1, 1'b1, 0);
            @(posedge clk_i);
            #1;
        end
        set_inputs(32'h0, 32'h0, 1'b0, 1'b0, 0);
        #2;
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if (o_dvld !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_dvld: got %b want 0", o_dvld);
        end
        n_cmp++;
        if (o_z !== 96'h0) begin
            n_bad++;
            $display("FAIL areset_z: got %h want 0", o_z);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        stale = 0;
        repeat (12) begin
            @(posedge clk_i);
            #1;
            if (o_dvld) stale++;
        end
        n_cmp++;
        if (stale !== 0) begin
            n_bad++;
            $display("FAIL areset_stale: got %0d valid outputs want 0", stale);
        end
        vx[0] = 32'h10;
        vy[0] = 32'h20;
        run_stream("post_rst", 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_bubbles();
        test_fixed_rand();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
